// File: rtl/multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
// Multicycle RV32I-subset control unit: sequences the shared-memory datapath
// through fetch/decode/execute, counts retired instructions, flags illegal opcodes.
module multicycle_ctrl_fsm #(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    logic             req, pcw, mw, irw, rw;
    logic [1:0]       alu_op;

    // Memory handshake: mem_req stays high in FETCH/MEMREAD/MEMWRITE until the
    // cycle mem_ready is also high; that cycle completes the access and only
    // then does the FSM advance.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        req       = 1'b0;
        pcw       = 1'b0;
        mw        = 1'b0;
        irw       = 1'b0;
        rw        = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            S_FETCH: begin
                req       = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = mem_ready;
                pcw       = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_d = 1'b1;
                        if (ILLEGAL_HALT) state_d = S_HALT;
                        else              state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_LW) state_d = S_MEMREAD;
                else             state_d = S_MEMWRITE;
            end
            S_MEMREAD: begin
                req    = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                req    = 1'b1;
                AdrSrc = 1'b1;
                mw     = mem_ready;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw        = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw      = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                pcw     = Zero;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw     = 1'b1;
                state_d = S_ALUWB;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Enables are masked while reset is held so nothing writes mid-reset.
    assign mem_req   = req & reset_n;
    assign PCWrite   = pcw & reset_n;
    assign MemWrite  = mw  & reset_n;
    assign IRWrite   = irw & reset_n;
    assign RegWrite  = rw  & reset_n;
    assign illegal   = illegal_q;
    assign instret   = instret_q;
    assign state_dbg = state_q;
endmodule
